// File: rtl/up3_pkg.sv
// Shared types and widths for the up3 RAM loader arbiter.
package up3_pkg;

    localparam int unsigned UP3_ADDR_W = 8;
    localparam int unsigned UP3_DATA_W = 8;

    typedef enum logic [2:0] {
        CPU_RUN  = 3'd0,
        WAIT_BND = 3'd1,
        LD_ADDR  = 3'd2,
        LD_DATA  = 3'd3,
        LD_WRITE = 3'd4,
        RESTART  = 3'd5
    } ldarb_state_t;

endpackage

// File: rtl/ram_load_arbiter_mux.sv
// Combinational owner select of the single RAM port between CPU and loader.
module ram_port_mux #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              sel_loader_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic              cpu_wren_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    input  logic              ld_wren_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_wren_o
);

    always_comb begin
        ram_addr_o  = cpu_addr_i;
        ram_wdata_o = cpu_wdata_i;
        ram_wren_o  = cpu_wren_i;
        if (sel_loader_i) begin
            ram_addr_o  = ld_addr_i;
            ram_wdata_o = ld_wdata_i;
            ram_wren_o  = ld_wren_i;
        end
    end

endmodule

// File: rtl/ram_load_arbiter.sv
// Hands the program RAM port to a byte-serial front-panel loader, stalling
// the control unit at a fetch boundary and releasing it when load_req drops.
module ram_load_arbiter
    import up3_pkg::*;
#(
    parameter int unsigned ADDR_W     = UP3_ADDR_W,
    parameter int unsigned DATA_W     = UP3_DATA_W,
    parameter bit          RESTART_PC = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              byte_stb,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              cpu_at_fetch,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    output logic              cpu_hold,
    output logic              cpu_restart,
    output logic              loader_busy,
    output logic [ADDR_W-1:0] load_count,
    output logic              wrap_err
);

    ldarb_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              wrap_q, wrap_d;
    logic              hold_q, hold_d;
    logic              restart_q, restart_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= CPU_RUN;
        else        state_q <= state_d;
    end

    // A falling load_req always beats a coincident byte strobe.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CPU_RUN:  if (load_req) state_d = WAIT_BND;
            WAIT_BND: begin
                if (!load_req)        state_d = CPU_RUN;
                else if (cpu_at_fetch) state_d = LD_ADDR;
            end
            LD_ADDR: begin
                if (!load_req)    state_d = RESTART;
                else if (byte_stb) state_d = LD_DATA;
            end
            LD_DATA: begin
                if (!load_req)    state_d = RESTART;
                else if (byte_stb) state_d = LD_WRITE;
            end
            LD_WRITE: state_d = load_req ? LD_DATA : RESTART;
            RESTART:  state_d = CPU_RUN;
            default:  state_d = CPU_RUN;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        data_d    = data_q;
        count_d   = count_q;
        wrap_d    = wrap_q;
        hold_d    = (state_d == WAIT_BND) || (state_d == LD_ADDR) ||
                    (state_d == LD_DATA)  || (state_d == LD_WRITE);
        busy_d    = (state_d == LD_ADDR) || (state_d == LD_DATA) ||
                    (state_d == LD_WRITE);
        restart_d = (state_d == RESTART) && RESTART_PC;
        unique case (state_q)
            WAIT_BND: if (load_req && cpu_at_fetch) begin
                count_d = '0;
                wrap_d  = 1'b0;
            end
            LD_ADDR:  if (load_req && byte_stb) addr_d = byte_in[ADDR_W-1:0];
            LD_DATA:  if (load_req && byte_stb) data_d = byte_in;
            LD_WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                if (&addr_q) wrap_d = 1'b1;
                if (!(&count_q)) count_d = count_q + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            data_q    <= '0;
            count_q   <= '0;
            wrap_q    <= 1'b0;
            hold_q    <= 1'b0;
            restart_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            data_q    <= data_d;
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            hold_q    <= hold_d;
            restart_q <= restart_d;
            busy_q    <= busy_d;
        end
    end

    assign cpu_hold    = hold_q;
    assign cpu_restart = restart_q;
    assign loader_busy = busy_q;
    assign load_count  = count_q;
    assign wrap_err    = wrap_q;

    ram_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .sel_loader_i (busy_q),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_wren_i   (cpu_wren),
        .ld_addr_i    (addr_q),
        .ld_wdata_i   (data_q),
        .ld_wren_i    (state_q == LD_WRITE),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_wren_o   (ram_wren)
    );

endmodule
